// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and stretch two raw active-low push-buttons into pressed levels and event pulses
// Ports: clk_clk system clock; reset_reset_n async active-low reset; key_n[1:0] raw buttons (bit 0 interrupt, bit 1 hour changer);
//   pressed[1:0] debounced held level; event_pulse[1:0] stretched press/repeat event.
// Optional feature macro BUTTON_AUTOREPEAT_EN: a held button emits repeated events.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES = 50000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [1:0] key_n,
  output logic [1:0] pressed,
  output logic [1:0] event_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  typedef enum logic {RELEASED, HELD} state_t;
  if (DEBOUNCE_CYCLES < 2 || PULSE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES <= PULSE_CYCLES) begin : g_bad_params
    $error("button_conditioner: invalid parameter set");
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0] sync;
    logic stable, accept, press_ev, ev, pulse_q;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] pulse_cnt, pulse_nxt;
    state_t state, state_nxt;
    always_comb begin
      accept = sync[1] != stable && db_cnt == DW'(DEBOUNCE_CYCLES);
      state_nxt = accept ? (sync[1] ? RELEASED : HELD) : state;
      press_ev = accept && !sync[1] && state == RELEASED;
      pulse_nxt = ev ? PW'(PULSE_CYCLES) : pulse_cnt - PW'(pulse_cnt != '0);
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
        sync <= 2'b11;
        stable <= 1'b1;
        db_cnt <= '0;
        state <= RELEASED;
        pulse_cnt <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync <= {sync[0], key_n[c]};
        stable <= accept ? sync[1] : stable;
        db_cnt <= (sync[1] == stable || accept) ? '0 : db_cnt + 1'b1;
        state <= state_nxt;
        pulse_cnt <= pulse_nxt;
        pulse_q <= pulse_nxt != '0;
      end
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RMAX = REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW = $clog2(RMAX + 1);
    logic [RW-1:0] rpt_cnt;
    logic rpt_first, rpt_run, rpt_ev;
    // a release being accepted this cycle already suppresses the repeat
    always_comb begin
      rpt_run = state == HELD && !accept;
      rpt_ev = rpt_run && rpt_cnt + 1'b1 == RW'(rpt_first ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES);
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
        rpt_cnt <= '0;
        rpt_first <= 1'b1;
      end else begin
        rpt_cnt <= (!rpt_run || rpt_ev) ? '0 : rpt_cnt + 1'b1;
        rpt_first <= rpt_ev ? 1'b0 : (rpt_run ? rpt_first : 1'b1);
      end
    assign ev = press_ev | rpt_ev;
`else
    assign ev = press_ev;
`endif
    assign pressed[c] = state == HELD;
    assign event_pulse[c] = pulse_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks of button_conditioner against a window-based reference model
module tb_button_conditioner;
  localparam int D = 8, P = 4, RD = 40, RP = 16;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int N_EV = 5, HI2 = 8;
`else
  localparam int N_EV = 1, HI2 = 4;
`endif
  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [1:0] pressed, event_pulse;
  logic [1:0] hist[$];
  logic [1:0] m_stable, exp_pressed, exp_pulse;
  int m_t, acc_t[2], ev_t[2];
  int passes = 0, fails = 0;
  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .key_n(key_n), .pressed(pressed), .event_pulse(event_pulse)
  );
  always #5 clk_clk = ~clk_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s t=%0d got %0h expected %0h", tag, m_t, got, exp);
    end
  endtask
  task automatic model_reset();
    hist = {};
    for (int k = 0; k < D + 3; k++) hist.push_back(2'b11);
    m_stable = 2'b11;
    m_t = 0;
    exp_pressed = '0;
    exp_pulse = '0;
    for (int c = 0; c < 2; c++) begin
      acc_t[c] = 0;
      ev_t[c] = -1000;
    end
  endtask
  // A level is accepted at edge t when the samples taken at edges t-2-D .. t-2 all differ from the accepted level.
  task automatic model_edge();
    logic flip;
    hist.push_back(key_n);
    void'(hist.pop_front());
    for (int c = 0; c < 2; c++) begin
      flip = 1'b1;
      for (int k = 0; k <= D; k++) if (hist[k][c] == m_stable[c]) flip = 1'b0;
      if (flip) begin
        m_stable[c] = ~m_stable[c];
        if (!m_stable[c]) begin
          acc_t[c] = m_t;
          ev_t[c] = m_t;
        end
      end
`ifdef BUTTON_AUTOREPEAT_EN
      else if (!m_stable[c] && m_t - acc_t[c] >= RD && (m_t - acc_t[c] - RD) % RP == 0) ev_t[c] = m_t;
`endif
      exp_pressed[c] = !m_stable[c];
      exp_pulse[c] = m_t - ev_t[c] < P;
    end
    m_t++;
  endtask
  task automatic step();
    @(posedge clk_clk);
    if (reset_reset_n) model_edge();
    @(negedge clk_clk);
    check("pressed", 32'(pressed), 32'(exp_pressed));
    check("event_pulse", 32'(event_pulse), 32'(exp_pulse));
  endtask
  task automatic run(input int n, input int b, output int pr, output int pf, output int hi, output int rs);
    logic pp, pe;
    pr = -1;
    pf = -1;
    hi = 0;
    rs = 0;
    pp = pressed[b];
    pe = event_pulse[b];
    for (int i = 0; i < n; i++) begin
      step();
      if (pressed[b] && !pp && pr < 0) pr = i;
      if (!pressed[b] && pp && pf < 0) pf = i;
      if (event_pulse[b]) hi++;
      if (event_pulse[b] && !pe) rs++;
      pp = pressed[b];
      pe = event_pulse[b];
    end
  endtask
  initial begin
    int pr, pf, hi, rs, pr2, pf2, hi2, rs2, rate;
    model_reset();
    key_n = 2'b00;
    repeat (4) step();
    reset_reset_n = 1'b1;
    run(12, 0, pr, pf, hi, rs);
    check("t1_press_edge", 32'(pr), 32'(10));
    check("t1_pulse_rises", 32'(rs), 32'(1));
    check("t1_both_pulse", 32'(event_pulse), 32'(2'b11));
    check("t1_both_pressed", 32'(pressed), 32'(2'b11));
    key_n = 2'b11;
    run(20, 0, pr, pf, hi, rs);
    check("t1_release_edge", 32'(pf), 32'(10));
    key_n = 2'b01;
    run(50, 1, pr, pf, hi, rs);
    check("t2_press_edge", 32'(pr), 32'(10));
    key_n = 2'b11;
    run(20, 1, pr2, pf2, hi2, rs2);
    check("t2_release_edge", 32'(pf2), 32'(10));
    check("t2_pulse_cycles", 32'(hi + hi2), 32'(HI2));
    for (int i = 0; i < 60; i++) begin
      key_n = ((i / 5) % 2 == 1) ? 2'b11 : 2'b10;
      step();
      if (pressed[0] || event_pulse[0]) hi2 = -1;
    end
    check("t3_bounce_quiet", 32'(hi2), 32'(0));
    key_n = 2'b10;
    run(35, 0, pr, pf, hi, rs);
    check("t3_press_edge", 32'(pr), 32'(10));
    check("t3_pulse_cycles", 32'(hi), 32'(P));
    check("t3_pulse_rises", 32'(rs), 32'(1));
    key_n = 2'b11;
    run(20, 0, pr, pf, hi, rs);
    check("t3_release_edge", 32'(pf), 32'(10));
    key_n = 2'b01;
    run(100, 1, pr, pf, hi, rs);
    check("t4_press_edge", 32'(pr), 32'(10));
    key_n = 2'b11;
    run(30, 1, pr2, pf2, hi2, rs2);
    check("t4_release_edge", 32'(pf2), 32'(10));
    check("t4_events", 32'(rs + rs2), 32'(N_EV));
    check("t4_pulse_cycles", 32'(hi + hi2), 32'(N_EV * P));
    key_n = 2'b00;
    run(10, 0, pr, pf, hi, rs);
    check("t5_early_quiet", 32'(hi), 32'(0));
    step();
    check("t5_pressed_both", 32'(pressed), 32'(2'b11));
    check("t5_pulse_both", 32'(event_pulse), 32'(2'b11));
    step();
    step();
    reset_reset_n = 1'b0;
    model_reset();
    #1;
    check("t5_rst_pressed", 32'(pressed), 32'(0));
    check("t5_rst_pulse", 32'(event_pulse), 32'(0));
    step();
    step();
    reset_reset_n = 1'b1;
    run(12, 0, pr, pf, hi, rs);
    check("t5_repress_edge", 32'(pr), 32'(10));
    check("t5_repress_both", 32'(pressed), 32'(2'b11));
    key_n = 2'b11;
    repeat (15) step();
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 1) ? 60 : 10;
      if ($urandom_range(0, rate - 1) == 0) key_n[0] = ~key_n[0];
      if ($urandom_range(0, rate + 1) == 0) key_n[1] = ~key_n[1];
      if ($urandom_range(0, 499) == 0) begin
        reset_reset_n = 1'b0;
        model_reset();
        #1;
        check("rand_rst_pressed", 32'(pressed), 32'(0));
        check("rand_rst_pulse", 32'(event_pulse), 32'(0));
        step();
        reset_reset_n = 1'b1;
      end
      step();
    end
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule
